// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, REQ, WAIT, HOLD)
//   ifid_t        : IF/ID pipeline register payload
//   NOP_INSTR     : bubble instruction, PC_STEP : sequential PC increment
package mips_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register plus the skid buffer that parks a word fetched
// while decode is stalled.
//   clk, rst_n            : clock, synchronous active-low reset
//   flush                 : load a bubble (highest priority)
//   hold                  : keep the current contents
//   load, use_skid        : load a real instruction from rdata or the skid
//   skid_we               : capture rdata into the skid buffer
//   rdata, load_pc4       : incoming instruction word and its PC+4
//   valid, instr, pc4     : register contents towards decode
module ifid_reg
    import mips_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            hold,
    input  logic            load,
    input  logic            use_skid,
    input  logic            skid_we,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] load_pc4,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc4
);

    ifid_t           q;
    logic [XLEN-1:0] skid;

    // A cycle that is neither stalled nor loading presents a bubble to decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '{valid: 1'b0, instr: BUBBLE_INSTR, pc4: '0};
            skid <= BUBBLE_INSTR;
        end else begin
            if (skid_we) begin
                skid <= rdata;
            end
            if (flush) begin
                q <= '{valid: 1'b0, instr: BUBBLE_INSTR, pc4: '0};
            end else if (!hold) begin
                if (load) begin
                    q <= '{valid: 1'b1, instr: (use_skid ? skid : rdata), pc4: load_pc4};
                end else begin
                    q <= '{valid: 1'b0, instr: BUBBLE_INSTR, pc4: '0};
                end
            end
        end
    end

    assign valid = q.valid;
    assign instr = q.instr;
    assign pc4   = q.pc4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one request per PC over a req/rvalid
// handshake, computes the next PC, and owns the IF/ID register.
//   clk, rst_n                 : clock, synchronous active-low reset
//   pc_in / pc_next            : current PC in, next PC to the pc register
//   stall                      : hazard stall, hold PC and IF/ID
//   redirect, redirect_pc      : taken branch / jump target
//   imem_req, imem_addr        : fetch request and its word address
//   imem_rvalid, imem_rdata    : memory response
//   ifid_valid/instr/pc4       : IF/ID register towards decode
//   fetch_err                  : one-cycle pulse when a request times out
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = mips_fetch_pkg::NOP_INSTR,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    fetch_state_t state;
    logic         drop;
    logic [CNT_W-1:0] cnt;

    logic [31:0] pc_plus4;
    logic        good;
    logic        accept;
    logic        release_skid;
    logic        to_skid;
    logic        timeout;

    assign imem_addr = pc_in;
    assign pc_plus4  = pc_in + PC_STEP;

    // Per-cycle decisions shared by the FSM, the PC mux and IF/ID.
    always_comb begin
        good         = (state == WAIT) && imem_rvalid && !drop;
        accept       = good && !stall;
        to_skid      = good && stall && !redirect;
        release_skid = (state == HOLD) && !stall;
        timeout      = (state == WAIT) && !imem_rvalid && (cnt == CNT_W'(TIMEOUT_CYC));
    end

    // Next PC: advance only when an instruction is handed to decode.
    always_comb begin
        pc_next = pc_in;
        if (!rst_n || state == IDLE) begin
            pc_next = RESET_PC;
        end else if (redirect) begin
            pc_next = redirect_pc;
        end else if (accept || release_skid) begin
            pc_next = pc_plus4;
        end
    end

    // Fetch FSM, timeout counter and stale-response drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            drop      <= 1'b0;
            cnt       <= '0;
            imem_req  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    // The request is already on the bus; a redirect now makes its answer stale.
                    state <= WAIT;
                    cnt   <= '0;
                    drop  <= drop | redirect;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop <= 1'b0;
                        cnt  <= '0;
                        if (to_skid) begin
                            state <= HOLD;
                        end else begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end
                    end else if (timeout) begin
                        drop      <= 1'b1;
                        cnt       <= '0;
                        fetch_err <= 1'b1;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (redirect) begin
                            drop <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    ifid_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .hold     (stall),
        .load     (accept || release_skid),
        .use_skid (release_skid),
        .skid_we  (to_skid),
        .rdata    (imem_rdata),
        .load_pc4 (pc_plus4),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .pc4      (ifid_pc4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed opening scenarios followed by random
// stall/redirect/reset/latency traffic, checked every cycle against a
// flag-based behavioural model, with literal expectations on key cycles.
module tb_fetch_unit;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam int unsigned TO      = 15;
    localparam int          DIR_END = 51;
    localparam int          N_CYC   = 4000;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        fetch_err;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .NOP_INSTR   (NOP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .pc_next     (pc_next),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External pc register.
    always @(posedge clk) pc_in <= pc_next;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h2009_0007;
        return ~a;
    endfunction

    function automatic int dir_lat(input int c);
        if (c == 14) return 3;
        if (c == 25) return 18;
        if (c == 42) return 2;
        return 1;
    endfunction

    // Pending memory responses keyed by delivery cycle.
    logic [31:0] resp [int];

    // Behavioural model state.
    bit          m_first, m_req_now, m_outst, m_drop, m_skid_full;
    int          m_wait;
    logic [31:0] m_skid;
    logic        e_valid, e_req, e_err;
    logic [31:0] e_instr, e_pc4, e_pcn;
    bit          have_exp;

    initial begin
        bit          got, good, tmo, deliver;
        logic [31:0] w, p4;
        int          due;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        have_exp = 0;
        m_first = 0; m_req_now = 0; m_outst = 0; m_drop = 0; m_skid_full = 0;
        m_wait = 0; m_skid = '0;
        e_valid = 0; e_req = 0; e_err = 0; e_instr = NOP; e_pc4 = '0; e_pcn = '0;

        for (int c = 0; c < N_CYC; c++) begin
            cyc = c;
            @(negedge clk);

            if (have_exp) begin
                chk("ifid_valid", 32'(ifid_valid), 32'(e_valid));
                chk("ifid_instr", ifid_instr, e_instr);
                chk("ifid_pc4", ifid_pc4, e_pc4);
                chk("imem_req", 32'(imem_req), 32'(e_req));
                chk("fetch_err", 32'(fetch_err), 32'(e_err));
            end

            if (c < DIR_END) begin
                rst_n       = (c >= 3);
                stall       = (c inside {8, 9, 10, 20, 21, 22});
                redirect    = (c == 15 || c == 22 || c == 47);
                redirect_pc = (c == 15) ? 32'h40 : (c == 22) ? 32'h80 :
                              (c == 47) ? 32'hFFFF_FFFC : 32'h0;
            end else begin
                rst_n       = ($urandom_range(0, 299) != 0);
                stall       = ($urandom_range(0, 3) == 0);
                redirect    = ($urandom_range(0, 11) == 0);
                redirect_pc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC
                                                          : ($urandom() & 32'hFFFF_FFFC);
            end

            if (!rst_n) resp.delete();
            if (resp.exists(c)) begin
                imem_rvalid = 1'b1;
                imem_rdata  = resp[c];
                resp.delete(c);
            end else if (c >= DIR_END && $urandom_range(0, 24) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom();
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom();
            end

            #1;

            // Model: what this cycle must produce and what the next edge must load.
            if (!rst_n) begin
                e_pcn = 32'h0;
                m_first = 1; m_req_now = 0; m_outst = 0; m_drop = 0; m_skid_full = 0; m_wait = 0;
                e_valid = 0; e_instr = NOP; e_pc4 = '0; e_req = 0; e_err = 0;
                chk("pc_next", pc_next, e_pcn);
            end else begin
                got     = m_outst && imem_rvalid;
                good    = got && !m_drop;
                tmo     = m_outst && !imem_rvalid && (m_wait == TO);
                deliver = !m_first && !redirect && !stall && (good || m_skid_full);
                w       = good ? imem_rdata : m_skid;
                p4      = pc_in + 32'd4;
                e_pcn   = m_first ? 32'h0 : redirect ? redirect_pc : deliver ? p4 : pc_in;
                chk("pc_next", pc_next, e_pcn);
                if (e_req) chk("imem_addr", imem_addr, pc_in);

                if (redirect || (!stall && !deliver)) begin
                    e_valid = 0; e_instr = NOP; e_pc4 = '0;
                end else if (deliver) begin
                    e_valid = 1; e_instr = w; e_pc4 = p4;
                end
                e_err = tmo;

                if (m_first) begin
                    m_first = 0; m_req_now = 1;
                end else if (m_req_now) begin
                    m_req_now = 0; m_outst = 1; m_wait = 0;
                    if (redirect) m_drop = 1;
                end else if (m_outst) begin
                    if (got) begin
                        m_outst = 0; m_drop = 0;
                        if (good && stall && !redirect) begin
                            m_skid_full = 1; m_skid = imem_rdata;
                        end else begin
                            m_req_now = 1;
                        end
                    end else begin
                        if (redirect) m_drop = 1;
                        if (tmo) begin
                            m_outst = 0; m_drop = 1; m_req_now = 1;
                        end else begin
                            m_wait++;
                        end
                    end
                end else if (m_skid_full) begin
                    if (redirect || !stall) begin
                        m_skid_full = 0; m_req_now = 1;
                    end
                end
                e_req = m_req_now;
            end
            have_exp = 1;

            // Hand-computed expectations for the directed opening.
            case (c)
                1: begin
                    chk("lit_rst_pcn", pc_next, 32'h0);
                    chk("lit_rst_valid", 32'(ifid_valid), 32'h0);
                    chk("lit_rst_instr", ifid_instr, NOP);
                    chk("lit_rst_req", 32'(imem_req), 32'h0);
                end
                3:  chk("lit_idle_pcn", pc_next, 32'h0);
                5:  chk("lit_pcn_4", pc_next, 32'h4);
                6: begin
                    chk("lit_instr0", ifid_instr, 32'h2008_0005);
                    chk("lit_pc4_0", ifid_pc4, 32'h4);
                end
                7:  chk("lit_pcn_8", pc_next, 32'h8);
                8: begin
                    chk("lit_instr1", ifid_instr, 32'h2009_0007);
                    chk("lit_pc4_1", ifid_pc4, 32'h8);
                end
                9:  chk("lit_stall_pcn", pc_next, 32'h8);
                10: begin
                    chk("lit_stall_pcn2", pc_next, 32'h8);
                    chk("lit_stall_hold", ifid_instr, 32'h2009_0007);
                end
                11: chk("lit_unstall_pcn", pc_next, 32'hC);
                12: begin
                    chk("lit_skid_instr", ifid_instr, 32'hFFFF_FFF7);
                    chk("lit_skid_pc4", ifid_pc4, 32'hC);
                end
                15: chk("lit_redir_pcn", pc_next, 32'h40);
                16: chk("lit_redir_valid", 32'(ifid_valid), 32'h0);
                18: begin
                    chk("lit_redir_req", 32'(imem_req), 32'h1);
                    chk("lit_redir_addr", imem_addr, 32'h40);
                end
                22: chk("lit_hold_redir_pcn", pc_next, 32'h80);
                23: begin
                    chk("lit_hold_flush", 32'(ifid_valid), 32'h0);
                    chk("lit_hold_addr", imem_addr, 32'h80);
                end
                25: chk("lit_after_hold", ifid_instr, 32'hFFFF_FF7F);
                41: begin
                    chk("lit_to_err0", 32'(fetch_err), 32'h0);
                    chk("lit_to_pcn", pc_next, 32'h84);
                end
                42: begin
                    chk("lit_to_err1", 32'(fetch_err), 32'h1);
                    chk("lit_to_reissue", imem_addr, 32'h84);
                end
                43: chk("lit_to_err_pulse", 32'(fetch_err), 32'h0);
                46: chk("lit_late_dropped", ifid_instr, 32'hFFFF_FF7B);
                49: chk("lit_wrap_pcn", pc_next, 32'h0);
                50: begin
                    chk("lit_wrap_pc4", ifid_pc4, 32'h0);
                    chk("lit_wrap_instr", ifid_instr, 32'h0000_0003);
                    chk("lit_wrap_valid", 32'(ifid_valid), 32'h1);
                end
                default: ;
            endcase

            // Memory accepts the request issued this cycle.
            if (rst_n && imem_req) begin
                due = c + ((c < DIR_END) ? dir_lat(c) : int'($urandom_range(1, 4)));
                while (resp.exists(due)) due++;
                resp[due] = (c == 25) ? 32'hDEAD_BEEF : word_at(imem_addr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: reads the current PC from the pc register, fetches the word from instruction memory over a req/rvalid handshake, and computes the next PC fed back to the pc register.
- Owns the IF/ID pipeline register and handles hazard stalls, branch/jump redirects, flushes and a memory-response timeout.
- Sits between the pc register, instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value driven on pc_next while in reset and on the first cycle after it.
- NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on flush or invalid.
- TIMEOUT_CYC, 15, cycles in WAIT before a request is abandoned and retried; counter width is clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pc_in  in  32  current PC from the pc register.
- pc_next  out  32  next PC to the pc register's in_address.
- stall  in  1  hazard-unit stall; hold PC and IF/ID.
- redirect  in  1  branch taken or jump resolved in a later stage.
- redirect_pc  in  32  target address, valid with redirect.
- imem_req  out  1  fetch request, one cycle per request.
- imem_addr  out  32  word address, equal to pc_in, valid with imem_req.
- imem_rvalid  in  1  response valid, 1 or more cycles after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc4  out  32  IF/ID PC+4.
- fetch_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc4=0, imem_req=0, fetch_err=0, drop=0, timeout cnt=0. pc_next=RESET_PC combinationally while rst_n=0. Reset mid-WAIT drops the outstanding response.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE -> REQ on the cycle after reset release.
  - REQ: imem_req=1, imem_addr=pc_in. Always -> WAIT next cycle.
  - WAIT, imem_rvalid=1 and drop=0, stall=0: IF/ID <= {1, rdata, pc_in+4}. pc_next=pc_in+4 that cycle. -> REQ.
  - WAIT, imem_rvalid=1 and drop=0, stall=1: capture rdata into a skid register. -> HOLD.
  - HOLD: IF/ID unchanged. pc_next=pc_in. When stall falls, load IF/ID from skid and pc_next=pc_in+4. -> REQ.
  - WAIT, imem_rvalid=1 and drop=1: discard the data, clear drop. -> REQ.
- pc_next default is pc_in (hold) in every state and cycle not listed above; no PC advance without a captured instruction.
- Redirect (highest priority over stall):
  - pc_next=redirect_pc in that cycle.
  - IF/ID <= {0, NOP_INSTR, 0}.
  - In WAIT without rvalid: set drop.
  - In WAIT with rvalid, or in HOLD: discard the word.
  - Next state REQ, except WAIT-without-rvalid, which stays in WAIT.
- Stall without redirect in REQ or WAIT: the request still completes; the response goes to the skid register as above. While stall=1, IF/ID is never overwritten.
- Timeout: cnt increments each cycle in WAIT and clears on leaving WAIT. At cnt==TIMEOUT_CYC: fetch_err=1 for one cycle, drop=1, -> REQ to reissue the same pc_in. A late response to an abandoned request is absorbed by drop.
- Arithmetic: pc_in+4 is a 32-bit add that wraps modulo 2^32; 32'hFFFF_FFFC+4 = 0.
- At most one outstanding request. imem_rvalid outside WAIT is ignored.

Decomposition:
- Shared package mips_fetch_pkg: fetch-state enum (IDLE/REQ/WAIT/HOLD), NOP_INSTR constant, PC_STEP=4.
- One natural sub-module: ifid_reg, the IF/ID register with load/flush/hold controls plus the skid buffer. The FSM, timeout counter and next-PC mux stay in fetch_unit.

Test Plan:
- Reset release, memory latency 1, words 0x20080005 and 0x20090007: pc_next sequence 0 -> 4 -> 8. ifid_instr=0x20080005 with ifid_pc4=4, then 0x20090007 with ifid_pc4=8.
- stall=1 for 3 cycles while a response arrives at pc=8: pc_next holds 8, IF/ID unchanged. When stall drops, IF/ID=(rdata, 12) and pc_next=12.
- redirect=1, redirect_pc=0x40 in WAIT at pc=0x10, response arrives 2 cycles later: the response is discarded, ifid_valid=0 with NOP_INSTR, the next imem_addr is 0x40.
- redirect and stall asserted together in HOLD: pc_next=redirect_pc, IF/ID flushed, the skid word is never presented.
- Memory silent for 15 cycles in WAIT: fetch_err pulses once, the same address is reissued, and a late response to the first request is dropped.
- pc_in=0xFFFF_FFFC with a clean fetch: pc_next=0x0000_0000, ifid_pc4=0.
